mem_arbiter: RTL and testbench

- Shares one synchronous single-port RAM between the CPU control path and a DMA/loader requester.
- The CPU side receives an address and write strobe derived from the control unit's mm/mw selection.
- The DMA side is used by the program loader and the debug port.
- Arbitrates per cycle, stalls the losing requester, routes read data back with fixed 1-cycle latency, and bounds DMA starvation with a CPU burst counter.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: shares one single-port sync RAM between CPU and DMA.         |
// | Optional: MEM_ARB_RR_EN selects strict alternation for contested cycles.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 8,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA, S_DMA_LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  if (MAX_CPU_BURST < 1 || MAX_CPU_BURST > 15) begin : g_bad_burst
    $error("mem_arbiter: MAX_CPU_BURST must be in 1..15");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_rd_owner;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          w_cpu_win;
  logic          w_dma_win;
  logic          w_contested;
  logic          w_locked;

`ifdef MEM_ARB_RR_EN
  logic          r_rr_dma_turn;
`else
  localparam logic [3:0] c_max_burst = 4'(MAX_CPU_BURST);
  logic [3:0]    r_burst;
`endif

  assign w_contested = cpu_req & dma_req;
  assign w_locked    = (r_state == S_DMA_LOCKED) & dma_lock;

  always_comb begin
    w_cpu_win   = 1'b0;
    w_dma_win   = 1'b0;
    w_state_nxt = S_IDLE;
    if (rst) begin
      w_cpu_win = 1'b0;
    end else if (cpu_req && !dma_req) begin
      w_cpu_win = 1'b1;
    end else if (dma_req && !cpu_req) begin
      w_dma_win = 1'b1;
    end else if (w_contested) begin
      if (w_locked) begin
        w_dma_win = 1'b1;
`ifdef MEM_ARB_RR_EN
      end else if (r_rr_dma_turn) begin
`else
      end else if (r_burst == c_max_burst) begin
`endif
        w_dma_win = 1'b1;
      end else begin
        w_cpu_win = 1'b1;
      end
    end
    if (w_cpu_win)      w_state_nxt = S_CPU;
    else if (w_dma_win) w_state_nxt = dma_lock ? S_DMA_LOCKED : S_DMA;
  end

  assign cpu_gnt   = w_cpu_win;
  assign dma_gnt   = w_dma_win;
  assign mem_en    = w_cpu_win | w_dma_win;
  assign mem_we    = w_cpu_win ? cpu_we    : (w_dma_win ? dma_we    : 1'b0);
  assign mem_addr  = w_cpu_win ? cpu_addr  : (w_dma_win ? dma_addr  : '0);
  assign mem_wdata = w_cpu_win ? cpu_wdata : (w_dma_win ? dma_wdata : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_owner  <= OWN_NONE;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cpu_win && !cpu_we)      r_rd_owner <= OWN_CPU;
      else if (w_dma_win && !dma_we) r_rd_owner <= OWN_DMA;
      else                           r_rd_owner <= OWN_NONE;
      if (r_rd_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
      if (r_rd_owner == OWN_DMA) r_dma_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Locked cycles do not move the alternation pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_rr_dma_turn <= 1'b0;
    else if (w_contested && !w_locked) r_rr_dma_turn <= w_cpu_win;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_burst <= '0;
    else if (!dma_req || w_dma_win)                 r_burst <= '0;
    else if (w_cpu_win && (r_burst != c_max_burst)) r_burst <= r_burst + 4'd1;
  end
`endif

  // RAM data arrives the cycle after the grant; expose it live, then hold it.
  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dma_rvalid = (r_rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign dma_rdata  = dma_rvalid ? mem_rdata : r_dma_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] ram [0:4095];

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_CPU_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[11:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic exp_dma;
    for (int a = 0; a < 4096; a++) ram[a] = '0;
    ram[12'h200] = 8'hA9;
    ram[12'h010] = 8'h11;
    ram[12'h020] = 8'h22;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;

    // Reset state, grants gated while rst is high
    repeat (2) @(negedge clk);
    cpu_req = 1; cpu_addr = 16'h0200;
    #1;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);

    // CPU read of 0x0200
    @(negedge clk); rst = 0; #1;
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_dma_gnt", dma_gnt, 0);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 16'h0200);
    @(negedge clk); cpu_req = 0; #1;
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 8'hA9);
    check("rd_dma_rvalid", dma_rvalid, 0);
    @(negedge clk); #1;
    check("rd_rvalid_drop", cpu_rvalid, 0);
    check("rd_rdata_hold", cpu_rdata, 8'hA9);
    check("idle_mem_en", mem_en, 0);
    check("idle_mem_addr", mem_addr, 0);

    // Reset mid-access discards pending rvalid
    @(negedge clk); cpu_req = 1; cpu_addr = 16'h0010; #1;
    check("mr_gnt", cpu_gnt, 1);
    @(posedge clk); #2; rst = 1; #1;
    check("mr_rvalid", cpu_rvalid, 0);
    check("mr_rdata", cpu_rdata, 0);
    check("mr_gnt_gated", cpu_gnt, 0);
    check("mr_mem_en", mem_en, 0);
    @(negedge clk); rst = 0; #1;
    check("mr_gnt_after", cpu_gnt, 1);
    @(negedge clk); cpu_req = 0; #1;
    check("mr_rd_rvalid", cpu_rvalid, 1);
    check("mr_rd_rdata", cpu_rdata, 8'h11);

    // Contention: burst limit (or strict alternation)
    @(negedge clk);
    cpu_req = 1; cpu_addr = 16'h0000;
    dma_req = 1; dma_addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_dma = (i % 2) == 1;
`else
      exp_dma = (i % 5) == 4;
`endif
      #1;
      check($sformatf("arb_cpu_gnt[%0d]", i), cpu_gnt, !exp_dma);
      check($sformatf("arb_dma_gnt[%0d]", i), dma_gnt, exp_dma);
      @(negedge clk);
    end

    // DMA lock burst
    cpu_req = 0; dma_lock = 1; dma_addr = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) cpu_req = 1;
      #1;
      check($sformatf("lock_dma_gnt[%0d]", i), dma_gnt, 1);
      check($sformatf("lock_cpu_gnt[%0d]", i), cpu_gnt, 0);
      @(negedge clk);
    end
    dma_lock = 0; #1;
    check("unlock_cpu_gnt", cpu_gnt, 1);
    check("unlock_dma_gnt", dma_gnt, 0);
    @(negedge clk); cpu_req = 0; #1;
    check("unlock_dma_only", dma_gnt, 1);
    check("unlock_mem_addr", mem_addr, 0);

    // Alternating reads, no cross-routing
    @(negedge clk); dma_req = 0; cpu_req = 1; cpu_addr = 16'h0010; #1;
    check("alt_cpu_gnt", cpu_gnt, 1);
    @(negedge clk); cpu_req = 0; dma_req = 1; dma_addr = 16'h0020; #1;
    check("alt_dma_gnt", dma_gnt, 1);
    check("alt_cpu_rvalid", cpu_rvalid, 1);
    check("alt_cpu_rdata", cpu_rdata, 8'h11);
    check("alt_dma_rvalid0", dma_rvalid, 0);
    check("alt_dma_rdata0", dma_rdata, 8'h00);
    @(negedge clk); dma_req = 0; #1;
    check("alt_dma_rvalid", dma_rvalid, 1);
    check("alt_dma_rdata", dma_rdata, 8'h22);
    check("alt_cpu_rvalid0", cpu_rvalid, 0);
    check("alt_cpu_hold", cpu_rdata, 8'h11);

    // DMA write, CPU read-back
    @(negedge clk); dma_req = 1; dma_we = 1; dma_addr = 16'h0300; dma_wdata = 8'h5A; #1;
    check("wr_dma_gnt", dma_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_wdata", mem_wdata, 8'h5A);
    @(negedge clk); dma_req = 0; dma_we = 0; cpu_req = 1; cpu_addr = 16'h0300; #1;
    check("wr_no_rvalid", dma_rvalid, 0);
    check("wb_cpu_gnt", cpu_gnt, 1);
    @(negedge clk); cpu_req = 0; #1;
    check("wb_cpu_rvalid", cpu_rvalid, 1);
    check("wb_cpu_rdata", cpu_rdata, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
